spi_master: RTL and testbench



---
 rtl/spi_master.sv | 142 ++++++++++++++
 tb/tb_spi_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, no chip select.
// A one-cycle start pulse in IDLE launches one 8-bit exchange. mosi leads and miso is
// sampled on the sck rising edge. done pulses for one cycle when the exchange finishes.
module spi_master #(
  parameter int unsigned CLK_DIV = 3  // log2 of clk cycles per sck period, >= 1
) (
  input  logic       clk,
  input  logic       rst,       // synchronous, active-low
  input  logic       miso,
  output logic       mosi,
  output logic       sck,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // div value just before sck rises, and just before sck falls (wrap to zero)
  localparam logic [CLK_DIV-1:0] DIV_MAX     = '1;
  localparam logic [CLK_DIV-1:0] DIV_HALF_M1 = DIV_MAX >> 1;
  localparam logic [CLK_DIV-1:0] DIV_ONE     = CLK_DIV'(1);

  state_t             state_r,    state_s;
  logic [CLK_DIV-1:0] div_r,      div_s;
  logic [2:0]         bitcnt_r,   bitcnt_s;
  logic [7:0]         tx_r,       tx_s;
  logic [7:0]         rx_r,       rx_s;
  logic [7:0]         data_out_r, data_out_s;
  logic               mosi_r,     mosi_s;
  logic               sck_r,      sck_s;
  logic               busy_r,     busy_s;
  logic               done_r,     done_s;

  // Next-state and next-output logic; every register gets its hold value first
  always_comb begin
    state_s    = state_r;
    div_s      = div_r;
    bitcnt_s   = bitcnt_r;
    tx_s       = tx_r;
    rx_s       = rx_r;
    data_out_s = data_out_r;
    mosi_s     = mosi_r;
    sck_s      = sck_r;
    busy_s     = busy_r;
    done_s     = 1'b0;

    case (state_r)
      IDLE: begin
        sck_s  = 1'b0;
        mosi_s = 1'b0;
        busy_s = 1'b0;
        if (start) begin
          // Capture the byte now so later data_in changes cannot disturb it
          tx_s     = data_in;
          mosi_s   = data_in[7];
          div_s    = '0;
          bitcnt_s = 3'd0;
          busy_s   = 1'b1;
          state_s  = XFER;
        end else begin
          state_s = IDLE;
        end
      end

      XFER: begin
        div_s = div_r + DIV_ONE;
        // sck mirrors the top div bit: low first half-period, high second half
        sck_s = div_s[CLK_DIV-1];
        if (div_r == DIV_HALF_M1) begin
          // sck is about to rise: slave data is stable, shift it in
          rx_s = {rx_r[6:0], miso};
        end else begin
          rx_s = rx_r;
        end
        if (div_r == DIV_MAX) begin
          // sck is about to fall: either advance to the next bit or finish
          if (bitcnt_r == 3'd7) begin
            state_s    = IDLE;
            done_s     = 1'b1;
            busy_s     = 1'b0;
            sck_s      = 1'b0;
            mosi_s     = 1'b0;
            data_out_s = rx_r;
          end else begin
            bitcnt_s = bitcnt_r + 3'd1;
            tx_s     = {tx_r[6:0], 1'b0};
            mosi_s   = tx_r[6];
          end
        end else begin
          bitcnt_s = bitcnt_r;
        end
      end

      default: begin
        state_s = IDLE;
        sck_s   = 1'b0;
        mosi_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      div_r      <= '0;
      bitcnt_r   <= 3'd0;
      tx_r       <= 8'h00;
      rx_r       <= 8'h00;
      data_out_r <= 8'h00;
      mosi_r     <= 1'b0;
      sck_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_r      <= div_s;
      bitcnt_r   <= bitcnt_s;
      tx_r       <= tx_s;
      rx_r       <= rx_s;
      data_out_r <= data_out_s;
      mosi_r     <= mosi_s;
      sck_r      <= sck_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign mosi     = mosi_r;
  assign sck      = sck_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign data_out = data_out_r;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed tests for spi_master with CLK_DIV=3.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       miso;
  logic       mosi;
  logic       sck;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       busy;
  logic       done;

  logic       loop_en  = 1'b0;
  logic       miso_val = 1'b0;

  int errors = 0;
  int checks = 0;

  // byte-level observations filled by do_byte
  logic [7:0] seq;
  logic [7:0] dout;
  int         rises;
  int         done_at;
  int         bad_run;
  int         busy_gap;

  assign miso = loop_en ? mosi : miso_val;

  spi_master #(.CLK_DIV(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .miso     (miso),
    .mosi     (mosi),
    .sck      (sck),
    .start    (start),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one byte and watch it cycle by cycle until done (bounded at 200 cycles).
  // k counts cycles after the edge that accepted start.
  task automatic do_byte(input logic [7:0] b, input int hold, input bit scramble);
    logic prev_sck;
    int   hi_run;
    int   lo_run;
    seq = 8'h00; dout = 8'h00; rises = 0; done_at = -1; bad_run = 0; busy_gap = 0;
    prev_sck = sck; hi_run = 0; lo_run = 0;
    start = 1'b1;
    data_in = b;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k >= hold) start = 1'b0;
      if (scramble) data_in = 8'(k * 37 + 11);
      if (sck && !prev_sck) begin
        rises++;
        seq = {seq[6:0], mosi};
        if (lo_run != 4) bad_run++;
        lo_run = 0;
      end
      if (!sck && prev_sck) begin
        if (hi_run != 4) bad_run++;
        hi_run = 0;
      end
      if (sck) hi_run++; else lo_run++;
      prev_sck = sck;
      if (done) begin
        done_at = k;
        dout = data_out;
        break;
      end
      if (!busy) busy_gap++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int sck_hi;
    int busy_hi;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got=%b exp=0", sck); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    rst = 1'b1;
    sck_hi = 0; busy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sck !== 1'b0) sck_hi++;
      if (busy !== 1'b0 || done !== 1'b0) busy_hi++;
    end
    checks++; if (sck_hi != 0) begin errors++; $display("FAIL idle_sck_toggles got=%0d exp=0", sck_hi); end
    checks++; if (busy_hi != 0) begin errors++; $display("FAIL idle_busy_done got=%0d exp=0", busy_hi); end
  endtask

  task automatic test_send_ae();
    loop_en = 1'b0; miso_val = 1'b1;
    tick();
    do_byte(8'hAE, 1, 1'b0);
    checks++; if (seq !== 8'hAE) begin errors++; $display("FAIL ae_mosi_bits got=%h exp=ae", seq); end
    checks++; if (rises != 8) begin errors++; $display("FAIL ae_sck_rises got=%0d exp=8", rises); end
    checks++; if (bad_run != 0) begin errors++; $display("FAIL ae_sck_duty bad_runs=%0d exp=0", bad_run); end
    checks++; if (done_at != 65) begin errors++; $display("FAIL ae_done_latency got=%0d exp=65", done_at); end
    checks++; if (busy_gap != 0) begin errors++; $display("FAIL ae_busy_gap got=%0d exp=0", busy_gap); end
    checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL ae_data_out got=%h exp=ff", dout); end
    checks++; if (busy !== 1'b0 || sck !== 1'b0 || mosi !== 1'b0) begin
      errors++; $display("FAIL ae_end_state busy=%b sck=%b mosi=%b exp=0,0,0", busy, sck, mosi);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ae_done_width got=%b exp=0", done); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL ae_data_out_hold got=%h exp=ff", data_out); end
  endtask

  task automatic test_back_to_back();
    loop_en = 1'b1;
    tick();
    do_byte(8'h8D, 1, 1'b0);
    checks++; if (done_at != 65) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=65", done_at); end
    checks++; if (dout !== 8'h8D) begin errors++; $display("FAIL b2b_first_data got=%h exp=8d", dout); end
    // next start issued in the done cycle itself
    do_byte(8'h14, 1, 1'b0);
    checks++; if (done_at != 65) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=65", done_at); end
    checks++; if (busy_gap != 0) begin errors++; $display("FAIL b2b_busy_gap got=%0d exp=0", busy_gap); end
    checks++; if (seq !== 8'h14) begin errors++; $display("FAIL b2b_second_mosi got=%h exp=14", seq); end
    checks++; if (dout !== 8'h14) begin errors++; $display("FAIL b2b_second_data got=%h exp=14", dout); end
    tick();
  endtask

  task automatic test_start_held();
    int extra;
    loop_en = 1'b1;
    do_byte(8'hF1, 20, 1'b0);
    checks++; if (done_at != 65) begin errors++; $display("FAIL held_latency got=%0d exp=65", done_at); end
    checks++; if (seq !== 8'hF1) begin errors++; $display("FAIL held_mosi got=%h exp=f1", seq); end
    checks++; if (dout !== 8'hF1) begin errors++; $display("FAIL held_data got=%h exp=f1", dout); end
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || sck !== 1'b0) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL held_no_queue got=%0d exp=0", extra); end
  endtask

  task automatic test_abort();
    int stray;
    loop_en = 1'b1;
    start = 1'b1; data_in = 8'hC3;
    tick();
    start = 1'b0;
    repeat (29) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (sck !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mosi !== 1'b0) begin
      errors++; $display("FAIL abort_state sck=%b busy=%b done=%b mosi=%b exp=0,0,0,0", sck, busy, done, mosi);
    end
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", stray); end
    do_byte(8'h00, 1, 1'b0);
    checks++; if (done_at != 65) begin errors++; $display("FAIL abort_retry_latency got=%0d exp=65", done_at); end
    checks++; if (dout !== 8'h00 || rises != 8) begin
      errors++; $display("FAIL abort_retry_data got=%h rises=%0d exp=00,8", dout, rises);
    end
    tick();
  endtask

  task automatic test_data_in_change();
    loop_en = 1'b0; miso_val = 1'b0;
    do_byte(8'h7F, 1, 1'b1);
    checks++; if (seq !== 8'h7F) begin errors++; $display("FAIL scramble_mosi got=%h exp=7f", seq); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL scramble_data got=%h exp=00", dout); end
    checks++; if (done_at != 65) begin errors++; $display("FAIL scramble_latency got=%0d exp=65", done_at); end
    tick();
  endtask

  initial begin
    test_reset();
    test_send_ae();
    test_back_to_back();
    test_start_held();
    test_abort();
    test_data_in_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
